req_priority_encoder: RTL and testbench
=======================================

Name: req_priority_encoder

Overview:
- Registered 8-input priority encoder with request latching and a valid/ready output handshake; the encode-direction counterpart of the team's 3-to-8 active-low decoder.
- Turns active-low request lines into a 3-bit index, highest index first, with 74x148-style enable, group-select and enable-out semantics.
- Sits in front of the lab CPU's interrupt/peripheral-select logic. One request event is delivered per handshake.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on each req_n bit (legal 2..3).
- N_REQ, 8, number of request lines. Fixed at 8 in this revision; the code width is 3.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- ei_n  input  1  enable, active-low, synchronous to clk.
- req_n  input  8  request lines, active-low, asynchronous level inputs.
- code  output  3  index of the granted request (7 = highest priority).
- valid  output  1  code is being offered.
- ready  input  1  consumer accepts code when valid=1.
- gs_n  output  1  group select: 0 when enabled and any request is pending.
- eo_n  output  1  enable out: 0 when enabled and nothing is pending.
- pending  output  8  latched, not-yet-delivered request events.
- overrun  output  1  sticky: a request event was lost.
- clr_ovr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async, rst_n=0): synchroniser flops=all 1; pending=0; code=0; valid=0; FSM=IDLE; overrun=0; gs_n=1; eo_n=1. Asserting reset mid-offer drops valid immediately and discards pending.
- Synchroniser: each req_n bit passes through SYNC_STAGES flops, followed by one history flop.
- Event detection: an event on bit i is the synchronised value going 1→0.
  - A level held low produces one event only. The line must return high and fall again to re-request.
- Pending update, per edge:
  - If ei_n=1, events are ignored (not latched). Existing pending bits are retained.
  - If ei_n=0, an event on bit i sets pending[i].
  - If pending[i] is already 1 and no clear of bit i occurs that edge, the event sets overrun.
  - If an event and an acceptance clear hit the same bit on the same edge, set wins and overrun is not set.
- overrun: sticky until clr_ovr=1 at a clock edge. A set on the same edge as clr_ovr wins.
- FSM states: IDLE, OFFER.
  - IDLE→OFFER when ei_n=0 and pending≠0. On that edge, code ← highest set index of pending and valid ← 1.
  - In OFFER, code and valid are held stable regardless of ei_n, new higher-priority events, or the pending contents. There is no preemption.
  - OFFER→IDLE on an edge with valid=1 and ready=1. On that edge, pending[code] ← 0 and valid ← 0.
  - valid is therefore low for at least one cycle between grants.
  - ready while valid=0 is ignored.
- Latency (SYNC_STAGES=2, IDLE, pending=0, ei_n=0), counting edge 1 as the first edge to sample req_n low:
  - pending set at edge 3;
  - valid=1 after edge 4.
  - Each extra sync stage adds 1 cycle.
- gs_n/eo_n: registered, computed from ei_n and the post-update pending of the same edge.
  - ei_n=1 → gs_n=1, eo_n=1.
  - ei_n=0 and pending≠0 → gs_n=0, eo_n=1.
  - ei_n=0 and pending=0 → gs_n=1, eo_n=0.

Test Plan:
- Reset release with req_n=8'hFF, ei_n=0 → valid=0, code=0, pending=0, gs_n=1, eo_n=0 after first edge; overrun=0.
- Single request: req_n[5] driven low, ready=1 → valid rises after edge 4 with code=5, pending=8'h20; next edge valid=0, pending=0, eo_n=0; holding req_n[5] low produces no second grant.
- Priority and no preemption: req_n[2] falls; while offering code=2 with ready=0, req_n[7] falls → code stays 2 until ready=1; then the next grant is code=7 after one idle cycle.
- Enable gating: ei_n=1 while req_n[3] falls → pending stays 0, gs_n=1, eo_n=1. ei_n=1 asserted during OFFER → the offer completes on ready; no new offer starts while ei_n=1.
- Overrun: req_n[4] pulses low-high-low twice with ready=0 → pending[4]=1, overrun=1. clr_ovr=1 for one cycle → overrun=0, pending[4] unchanged.
- Async reset mid-offer: valid=1, code=6; rst_n pulsed low between edges → valid=0, pending=0, gs_n=1 without waiting for a clock edge.

Source files
------------

// File: rtl/req_priority_encoder.sv
// Registered 8-input priority encoder: synchronised active-low request lines are edge-latched
// into pending events and offered one at a time, highest index first, over valid/ready.
module req_priority_encoder #(
    parameter int SYNC_STAGES = 2,
    parameter int N_REQ       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ei_n,
    input  logic [7:0] req_n,
    output logic [2:0] code,
    output logic       valid,
    input  logic       ready,
    output logic       gs_n,
    output logic       eo_n,
    output logic [7:0] pending,
    output logic       overrun,
    input  logic       clr_ovr
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Highest set index of a request vector; 0 when empty.
    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = i[2:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0] hist_q;
    logic [7:0] pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       gs_n_q, gs_n_d;
    logic       eo_n_q, eo_n_d;
    state_t     state_q, state_d;

    logic [7:0] event_s;
    logic [7:0] set_s;
    logic [7:0] clr_s;
    logic       accept_s;

    // Synchroniser chain plus history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{8'hFF}};
            hist_q <= 8'hFF;
        end else begin
            sync_q[0] <= req_n;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Event latching, acceptance clear and sticky overrun; a set beats a same-edge clear.
    always_comb begin
        event_s   = hist_q & ~sync_q[SYNC_STAGES-1];
        accept_s  = valid_q & ready;
        set_s     = ei_n ? 8'h00 : event_s;
        clr_s     = accept_s ? (8'h01 << code_q) : 8'h00;
        pending_d = (pending_q & ~clr_s) | set_s;
        overrun_d = (|(set_s & pending_q & ~clr_s)) | (overrun_q & ~clr_ovr);
        if (ei_n) begin
            gs_n_d = 1'b1;
            eo_n_d = 1'b1;
        end else begin
            gs_n_d = (pending_d == 8'h00);
            eo_n_d = (pending_d != 8'h00);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: no preemption once an offer is up.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!ei_n && (pending_q != 8'h00)) begin
                    state_d = OFFER;
                end else begin
                    state_d = IDLE;
                end
            end
            OFFER: begin
                if (accept_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = OFFER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: code captured only on the grant edge, held otherwise.
    always_comb begin
        valid_d = (state_d == OFFER);
        if ((state_q == IDLE) && (state_d == OFFER)) begin
            code_d = prio_idx(pending_q);
        end else begin
            code_d = code_q;
        end
    end

    // Output and pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 8'h00;
            overrun_q <= 1'b0;
            code_q    <= 3'd0;
            valid_q   <= 1'b0;
            gs_n_q    <= 1'b1;
            eo_n_q    <= 1'b1;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            gs_n_q    <= gs_n_d;
            eo_n_q    <= eo_n_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign gs_n    = gs_n_q;
    assign eo_n    = eo_n_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_req_priority_encoder.sv
// Directed bench for req_priority_encoder with hand-computed expectations.
module tb_req_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic       ei_n;
    logic [7:0] req_n;
    logic [2:0] code;
    logic       valid;
    logic       ready;
    logic       gs_n;
    logic       eo_n;
    logic [7:0] pending;
    logic       overrun;
    logic       clr_ovr;

    int checks;
    int failures;
    int grants;

    req_priority_encoder #(.SYNC_STAGES(2), .N_REQ(8)) dut (
        .clk(clk), .rst_n(rst_n), .ei_n(ei_n), .req_n(req_n),
        .code(code), .valid(valid), .ready(ready), .gs_n(gs_n),
        .eo_n(eo_n), .pending(pending), .overrun(overrun), .clr_ovr(clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; ei_n = 1'b0; req_n = 8'hFF; ready = 1'b0; clr_ovr = 1'b0;
        #22;
        chk("rst_valid", {7'd0, valid}, 8'd0);
        chk("rst_code", {5'd0, code}, 8'd0);
        chk("rst_pending", pending, 8'h00);
        chk("rst_gs_n", {7'd0, gs_n}, 8'd1);
        chk("rst_eo_n", {7'd0, eo_n}, 8'd1);
        chk("rst_overrun", {7'd0, overrun}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        chk("rel_eo_n", {7'd0, eo_n}, 8'd0);
        chk("rel_gs_n", {7'd0, gs_n}, 8'd1);
        chk("rel_valid", {7'd0, valid}, 8'd0);

        // Single request on bit 5
        req_n = 8'hDF; ready = 1'b1;
        tick(3);
        chk("s_pend_e3", pending, 8'h20);
        chk("s_valid_e3", {7'd0, valid}, 8'd0);
        chk("s_gs_e3", {7'd0, gs_n}, 8'd0);
        tick(1);
        chk("s_valid_e4", {7'd0, valid}, 8'd1);
        chk("s_code_e4", {5'd0, code}, 8'd5);
        chk("s_pend_e4", pending, 8'h20);
        tick(1);
        chk("s_valid_e5", {7'd0, valid}, 8'd0);
        chk("s_pend_e5", pending, 8'h00);
        chk("s_eo_e5", {7'd0, eo_n}, 8'd0);
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (valid) grants++;
        end
        chk("s_no_regrant", grants[7:0], 8'd0);
        req_n = 8'hFF; ready = 1'b0;
        tick(3);

        // Priority without preemption
        req_n = 8'hFB;
        tick(4);
        chk("p_valid2", {7'd0, valid}, 8'd1);
        chk("p_code2", {5'd0, code}, 8'd2);
        req_n = 8'h7B;
        tick(3);
        chk("p_pend84", pending, 8'h84);
        chk("p_hold_code", {5'd0, code}, 8'd2);
        tick(2);
        chk("p_hold_code2", {5'd0, code}, 8'd2);
        chk("p_hold_valid", {7'd0, valid}, 8'd1);
        ready = 1'b1;
        tick(1);
        chk("p_acc_valid", {7'd0, valid}, 8'd0);
        chk("p_acc_pend", pending, 8'h80);
        tick(1);
        chk("p_valid7", {7'd0, valid}, 8'd1);
        chk("p_code7", {5'd0, code}, 8'd7);
        tick(1);
        chk("p_done_valid", {7'd0, valid}, 8'd0);
        chk("p_done_pend", pending, 8'h00);
        req_n = 8'hFF; ready = 1'b0;
        tick(3);

        // Enable gating while idle
        ei_n = 1'b1; req_n = 8'hF7;
        tick(5);
        chk("e_pend", pending, 8'h00);
        chk("e_gs_n", {7'd0, gs_n}, 8'd1);
        chk("e_eo_n", {7'd0, eo_n}, 8'd1);
        chk("e_valid", {7'd0, valid}, 8'd0);
        ei_n = 1'b0;
        tick(2);
        chk("e_pend_after", pending, 8'h00);
        chk("e_eo_after", {7'd0, eo_n}, 8'd0);
        req_n = 8'hFF;
        tick(3);

        // Enable dropped during an offer
        req_n = 8'hFD;
        tick(4);
        chk("eo_valid1", {7'd0, valid}, 8'd1);
        chk("eo_code1", {5'd0, code}, 8'd1);
        req_n = 8'hBD;
        tick(3);
        chk("eo_pend42", pending, 8'h42);
        ei_n = 1'b1;
        tick(1);
        chk("eo_hold_valid", {7'd0, valid}, 8'd1);
        chk("eo_hold_code", {5'd0, code}, 8'd1);
        chk("eo_gs_dis", {7'd0, gs_n}, 8'd1);
        chk("eo_eo_dis", {7'd0, eo_n}, 8'd1);
        ready = 1'b1;
        tick(1);
        chk("eo_acc_valid", {7'd0, valid}, 8'd0);
        chk("eo_acc_pend", pending, 8'h40);
        ready = 1'b0;
        tick(3);
        chk("eo_no_offer", {7'd0, valid}, 8'd0);
        chk("eo_keep_pend", pending, 8'h40);
        ei_n = 1'b0;
        tick(1);
        chk("eo_valid6", {7'd0, valid}, 8'd1);
        chk("eo_code6", {5'd0, code}, 8'd6);
        ready = 1'b1;
        tick(1);
        chk("eo_done_pend", pending, 8'h00);
        ready = 1'b0; req_n = 8'hFF;
        tick(3);

        // Overrun
        req_n = 8'hEF;
        tick(3);
        chk("o_pend1", pending, 8'h10);
        chk("o_ovr0", {7'd0, overrun}, 8'd0);
        req_n = 8'hFF;
        tick(3);
        req_n = 8'hEF;
        tick(3);
        chk("o_pend2", pending, 8'h10);
        chk("o_ovr1", {7'd0, overrun}, 8'd1);
        tick(2);
        chk("o_sticky", {7'd0, overrun}, 8'd1);
        clr_ovr = 1'b1;
        tick(1);
        clr_ovr = 1'b0;
        chk("o_cleared", {7'd0, overrun}, 8'd0);
        chk("o_pend_kept", pending, 8'h10);
        chk("o_code4", {5'd0, code}, 8'd4);
        ready = 1'b1;
        tick(1);
        chk("o_acc_pend", pending, 8'h00);
        ready = 1'b0; req_n = 8'hFF;
        tick(3);

        // Async reset mid-offer
        req_n = 8'hBF;
        tick(4);
        chk("r_valid6", {7'd0, valid}, 8'd1);
        chk("r_code6", {5'd0, code}, 8'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("r_valid_async", {7'd0, valid}, 8'd0);
        chk("r_pend_async", pending, 8'h00);
        chk("r_gs_async", {7'd0, gs_n}, 8'd1);
        #1 rst_n = 1'b1;
        req_n = 8'hFF;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
